// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: loads a length-prefixed little-endian program from a UART byte stream
// into instruction memory, then runs the core (free-run or single-step) until it halts.
module cpu_boot_ctrl #(
    parameter int unsigned IMEM_ADDR_W = 10,
    parameter logic [31:0] HALT_INSTR  = 32'h0000006F,
    parameter int unsigned CYCLE_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   cpu_reset,
    output logic                   cpu_en,
    input  logic                   step_mode,
    input  logic                   step,
    input  logic [31:0]            cpu_pc,
    input  logic [31:0]            cpu_instr,
    output logic                   busy,
    output logic                   halted,
    output logic                   err,
    output logic [31:0]            halt_pc,
    output logic [CYCLE_W-1:0]     cycle_count
);

    typedef enum logic [2:0] {
        StLoadLen, StLoadWord, StRelease, StRun, StHalted, StError
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [15:0]            len_q, len_d;
    logic [IMEM_ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [23:0]            buf_q, buf_d;
    logic                   we_q, we_d;
    logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            halt_pc_q, halt_pc_d;
    logic [CYCLE_W-1:0]     cycle_q, cycle_d;

    logic        accept;
    logic [15:0] len_next;
    logic        len_bad;
    logic        last_word;

    assign rx_ready  = !reset && (state_q == StLoadLen || state_q == StLoadWord ||
                                  state_q == StHalted);
    assign accept    = rx_valid && rx_ready;
    assign cpu_reset = reset || !(state_q == StRun || state_q == StHalted);
    assign busy      = state_q == StLoadLen || state_q == StLoadWord || state_q == StRelease;
    assign halted    = state_q == StHalted;
    assign err       = state_q == StError;

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cycle_q;

    assign len_next  = {rx_data, buf_q[7:0]};
    assign len_bad   = (len_next == 16'd0) || (32'(len_next) > (32'd1 << IMEM_ADDR_W));
    assign last_word = 32'(word_idx_q) == (32'(len_q) - 32'd1);

    always_comb begin
        cpu_en = 1'b0;
        if (!reset) begin
            if (state_q == StRelease) cpu_en = 1'b1;
            else if (state_q == StRun) cpu_en = step_mode ? step : 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        buf_d      = buf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        halt_pc_d  = halt_pc_q;
        cycle_d    = cycle_q;
        unique case (state_q)
            StLoadLen: begin
                if (accept) begin
                    if (byte_idx_q == 2'd0) begin
                        buf_d[7:0] = rx_data;
                        byte_idx_d = 2'd1;
                    end else begin
                        byte_idx_d = 2'd0;
                        if (len_bad) begin
                            state_d = StError;
                        end else begin
                            len_d      = len_next;
                            word_idx_d = '0;
                            state_d    = StLoadWord;
                        end
                    end
                end
            end
            StLoadWord: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: buf_d[7:0]   = rx_data;
                        2'd1: buf_d[15:8]  = rx_data;
                        2'd2: buf_d[23:16] = rx_data;
                        2'd3: begin
                            we_d       = 1'b1;
                            addr_d     = word_idx_q;
                            wdata_d    = {rx_data, buf_q};
                            word_idx_d = word_idx_q + 1'b1;
                            if (last_word) state_d = StRelease;
                        end
                    endcase
                end
            end
            StRelease: state_d = StRun;
            StRun: begin
                if (cpu_en) begin
                    if (cycle_q != '1) cycle_d = cycle_q + CYCLE_W'(1);
                    if (cpu_instr == HALT_INSTR) begin
                        halt_pc_d = cpu_pc;
                        state_d   = StHalted;
                    end
                end
            end
            StHalted: begin
                // A new byte starts the next load as its low length byte.
                if (accept) begin
                    buf_d[7:0] = rx_data;
                    byte_idx_d = 2'd1;
                    cycle_d    = '0;
                    state_d    = StLoadLen;
                end
            end
            StError: ;
            default: state_d = StError;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLoadLen;
            byte_idx_q <= 2'd0;
            len_q      <= 16'd0;
            word_idx_q <= '0;
            buf_q      <= 24'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            halt_pc_q  <= 32'd0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            buf_q      <= buf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            halt_pc_q  <= halt_pc_d;
            cycle_q    <= cycle_d;
        end
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Table-driven bench for cpu_boot_ctrl with a behavioural instruction memory and PC model.
module tb_cpu_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        cpu_en;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] halt_pc;
    logic [31:0] cycle_count;

    cpu_boot_ctrl dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_en(cpu_en), .step_mode(step_mode), .step(step),
        .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .busy(busy), .halted(halted), .err(err),
        .halt_pc(halt_pc), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Instruction memory and a minimal core: PC advances by 4 on each enabled cycle.
    logic [31:0] imem_m [1024];
    logic [31:0] pc_m;
    logic [9:0]  wr_a [$];
    logic [31:0] wr_d [$];
    int          rel_cnt;

    assign cpu_pc    = pc_m;
    assign cpu_instr = imem_m[pc_m[11:2]];

    always @(posedge clk) begin
        if (cpu_en) pc_m <= cpu_reset ? 32'd0 : pc_m + 32'd4;
        if (imem_we) begin
            imem_m[imem_addr] <= imem_wdata;
            wr_a.push_back(imem_addr);
            wr_d.push_back(imem_wdata);
            if (cpu_reset && cpu_en) rel_cnt <= rel_cnt + 1;
        end
    end

    typedef struct {
        int          len;
        int          nw;
        logic [31:0] w [4];
        bit          gaps;
        bit          stepm;
        bit          exp_err;
        logic [31:0] exp_hpc;
        logic [31:0] exp_cyc;
    } vec_t;

    vec_t vecs [5];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(int len, int nw, logic [31:0] w0, logic [31:0] w1,
                                logic [31:0] w2, logic [31:0] w3, bit gaps, bit stepm,
                                bit e, logic [31:0] hpc, logic [31:0] cyc);
        vec_t v;
        v.len = len; v.nw = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.gaps = gaps; v.stepm = stepm; v.exp_err = e;
        v.exp_hpc = hpc; v.exp_cyc = cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte: rx_ready got 0 expected 1");
        end
        @(posedge clk);
        if (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_prog(input int len, input int nw, input logic [31:0] w [4],
                             input bit gap);
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        for (int i = 0; i < nw; i++)
            for (int j = 0; j < 4; j++) send_byte(w[i][8*j +: 8], gap);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1 check("rx_ready_in_reset", rx_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr_a.delete();
        wr_d.delete();
        rel_cnt = 0;
    endtask

    task automatic check_reset_state();
        check("rst_busy", busy, 1);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_halt_pc", halt_pc, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_rx_ready", rx_ready, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!(halted || err) && t < 60) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic check_writes(input string tag, input int nw, input logic [31:0] w [4]);
        check({tag, "_nwrites"}, wr_a.size(), nw);
        for (int i = 0; i < nw && i < wr_a.size(); i++) begin
            check({tag, "_waddr"}, wr_a[i], i);
            check({tag, "_wdata"}, wr_d[i], w[i]);
        end
    endtask

    initial begin
        logic [31:0] wa [4];
        pc_m = 32'd0;
        rel_cnt = 0;
        for (int i = 0; i < 1024; i++) imem_m[i] = 32'd0;

        vecs[0] = mk(2, 2, 32'h00500093, 32'h0000006F, 0, 0, 0, 0, 0, 32'h4, 32'd2);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[2] = mk(16'h0401, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[3] = mk(2, 2, 32'h00500093, 32'h0000006F, 0, 0, 1, 0, 0, 32'h4, 32'd2);
        vecs[4] = mk(4, 4, 32'h00100093, 32'h00200113, 32'h00300193, 32'h0000006F,
                     0, 1, 0, 32'hC, 32'd4);

        for (int v = 0; v < 5; v++) begin
            step_mode = vecs[v].stepm;
            do_reset();
            #1 check_reset_state();
            send_prog(vecs[v].len, vecs[v].nw, vecs[v].w, vecs[v].gaps);
            if (vecs[v].exp_err) begin
                rx_valid = 1'b1;
                repeat (3) @(negedge clk);
                check("err_flag", err, 1);
                check("err_rx_ready", rx_ready, 0);
                check("err_cpu_en", cpu_en, 0);
                check("err_cpu_reset", cpu_reset, 1);
                check("err_nwrites", wr_a.size(), 0);
                rx_valid = 1'b0;
            end else begin
                if (vecs[v].stepm) begin
                    int t = 0;
                    while (busy && t < 10) begin
                        @(negedge clk);
                        t++;
                    end
                    check("step_in_run", busy, 0);
                    rx_valid = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        #1 check("run_rx_ready", rx_ready, 0);
                        @(negedge clk);
                    end
                    rx_valid = 1'b0;
                    check("step_cnt_idle", cycle_count, 0);
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        step = 1'b0;
                        #1 check("step_idle_en", cpu_en, 0);
                        @(negedge clk);
                        step = 1'b1;
                        #1 check("step_pulse_en", cpu_en, 1);
                    end
                    @(negedge clk);
                    step = 1'b0;
                end else begin
                    wait_done();
                end
                wa = vecs[v].w;
                check_writes("vec", vecs[v].nw, wa);
                check("release_write", rel_cnt, 1);
                check("halted", halted, 1);
                check("halt_pc", halt_pc, vecs[v].exp_hpc);
                check("cycle_count", cycle_count, vecs[v].exp_cyc);
                check("halt_cpu_reset", cpu_reset, 0);
                check("halt_cpu_en", cpu_en, 0);
            end
        end

        // Reset in the middle of word 0, then a clean reload.
        step_mode = 1'b0;
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b0;
        do_reset();
        #1 check_reset_state();
        wa[0] = 32'h00000013; wa[1] = 32'h0000006F; wa[2] = 0; wa[3] = 0;
        send_prog(2, 2, wa, 0);
        wait_done();
        check_writes("midrst", 2, wa);
        check("midrst_halted", halted, 1);
        check("midrst_halt_pc", halt_pc, 32'h4);
        check("midrst_cycles", cycle_count, 2);

        // Reload straight from HALTED.
        wr_a.delete();
        wr_d.delete();
        send_byte(8'h01, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        check("reload_halted_clr", halted, 0);
        check("reload_cycles_clr", cycle_count, 0);
        check("reload_cpu_reset", cpu_reset, 1);
        send_byte(8'h00, 0);
        wa[0] = 32'h0000006F;
        for (int j = 0; j < 4; j++) send_byte(wa[0][8*j +: 8], 0);
        @(negedge clk);
        rx_valid = 1'b0;
        wait_done();
        check_writes("reload", 1, wa);
        check("reload_halted", halted, 1);
        check("reload_halt_pc", halt_pc, 32'h0);
        check("reload_cycles", cycle_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
